// File: rtl/uart_msg_packetizer_if.sv
// Handshake bundle between the UART input stage, the packetizer and the
// redirection fabric stream. The packetizer uses the master view.
interface uart_msg_packetizer_if;
   logic        GOT_FULL_MESSAGE;
   logic [7:0]  MSG_LEN;
   logic        PARITY_IN;
   logic [15:0] FIFO_Q;
   logic        MSG_START;
   logic        RD_REQ;
   logic [15:0] TX_DATA;
   logic        TX_VALID;
   logic        TX_READY;
   logic        TX_LAST;
   logic        BUSY;

   modport master (
      input  GOT_FULL_MESSAGE, MSG_LEN, PARITY_IN, FIFO_Q, TX_READY,
      output MSG_START, RD_REQ, TX_DATA, TX_VALID, TX_LAST, BUSY
   );

   modport slave (
      output GOT_FULL_MESSAGE, MSG_LEN, PARITY_IN, FIFO_Q, TX_READY,
      input  MSG_START, RD_REQ, TX_DATA, TX_VALID, TX_LAST, BUSY
   );
endinterface

// File: rtl/uart_msg_packetizer.sv
// Drains one complete message from the UART input stage FIFO and frames it as
// header + payload (+ XOR trailer when UART_PKT_CHECKSUM_EN is defined).
module uart_msg_packetizer #(
   parameter logic [3:0] SRC_ID     = 4'h1,
   parameter int         SETTLE_CYC = 3
) (
   input  logic                          CLK,
   input  logic                          RST,
   uart_msg_packetizer_if.master         bus
);

`ifdef UART_PKT_CHECKSUM_EN
   localparam logic CK_BIT = 1'b1;
`else
   localparam logic CK_BIT = 1'b0;
`endif
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_SETTLE, S_HEADER, S_READ, S_WAIT, S_SEND,
`ifdef UART_PKT_CHECKSUM_EN
      S_TRAILER,
`endif
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  settle_q, settle_d;
   logic [7:0]  len_q, len_d;
   logic [7:0]  rem_q, rem_d;
   logic        msg_start_q, msg_start_d;
   logic        rd_req_q, rd_req_d;
   logic [15:0] tx_data_q, tx_data_d;
   logic        tx_valid_q, tx_valid_d;
   logic        tx_last_q, tx_last_d;
   logic        busy_q, busy_d;
`ifdef UART_PKT_CHECKSUM_EN
   logic [15:0] xor_q, xor_d;
`endif

   function automatic logic [15:0] header_word(input logic par, input logic [7:0] len);
      return {SRC_ID, par, CK_BIT, 2'b00, len};
   endfunction

   always_comb begin
      state_d     = state_q;
      settle_d    = settle_q;
      len_d       = len_q;
      rem_d       = rem_q;
      msg_start_d = 1'b0;
      rd_req_d    = 1'b0;
      tx_data_d   = tx_data_q;
      tx_valid_d  = tx_valid_q;
      tx_last_d   = tx_last_q;
`ifdef UART_PKT_CHECKSUM_EN
      xor_d       = xor_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.GOT_FULL_MESSAGE) begin
               state_d     = S_START;
               msg_start_d = 1'b1;
            end
         end
         S_START: begin
            state_d  = S_SETTLE;
            settle_d = 4'd0;
         end
         // Length/parity are only trusted once the stuffing write has landed.
         S_SETTLE: begin
            if (settle_q == SETTLE_LAST) begin
               len_d      = bus.MSG_LEN;
               rem_d      = bus.MSG_LEN;
               tx_data_d  = header_word(bus.PARITY_IN, bus.MSG_LEN);
               tx_valid_d = 1'b1;
               tx_last_d  = (bus.MSG_LEN == 8'd0) & ~CK_BIT;
               state_d    = S_HEADER;
            end else begin
               settle_d = settle_q + 4'd1;
            end
         end
         S_HEADER: begin
`ifdef UART_PKT_CHECKSUM_EN
            xor_d = 16'h0000;
`endif
            if (bus.TX_READY) begin
               if (len_q == 8'd0) begin
`ifdef UART_PKT_CHECKSUM_EN
                  tx_data_d = 16'h0000;
                  tx_last_d = 1'b1;
                  state_d   = S_TRAILER;
`else
                  tx_valid_d = 1'b0;
                  tx_last_d  = 1'b0;
                  state_d    = S_DONE;
`endif
               end else begin
                  tx_valid_d = 1'b0;
                  tx_last_d  = 1'b0;
                  rd_req_d   = 1'b1;
                  state_d    = S_READ;
               end
            end
         end
         S_READ: begin
            rem_d   = rem_q - 8'd1;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            tx_data_d  = bus.FIFO_Q;
            tx_valid_d = 1'b1;
            tx_last_d  = (rem_q == 8'd0) & ~CK_BIT;
`ifdef UART_PKT_CHECKSUM_EN
            xor_d      = xor_q ^ bus.FIFO_Q;
`endif
            state_d    = S_SEND;
         end
         S_SEND: begin
            if (bus.TX_READY) begin
               tx_valid_d = 1'b0;
               tx_last_d  = 1'b0;
               if (rem_q != 8'd0) begin
                  rd_req_d = 1'b1;
                  state_d  = S_READ;
               end else begin
`ifdef UART_PKT_CHECKSUM_EN
                  tx_data_d  = xor_q;
                  tx_valid_d = 1'b1;
                  tx_last_d  = 1'b1;
                  state_d    = S_TRAILER;
`else
                  state_d    = S_DONE;
`endif
               end
            end
         end
`ifdef UART_PKT_CHECKSUM_EN
         S_TRAILER: begin
            if (bus.TX_READY) begin
               tx_valid_d = 1'b0;
               tx_last_d  = 1'b0;
               state_d    = S_DONE;
            end
         end
`endif
         // One dead cycle so the upstream flag can drop before re-sampling.
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q     <= S_IDLE;
         settle_q    <= 4'd0;
         len_q       <= 8'd0;
         rem_q       <= 8'd0;
         msg_start_q <= 1'b0;
         rd_req_q    <= 1'b0;
         tx_data_q   <= 16'h0000;
         tx_valid_q  <= 1'b0;
         tx_last_q   <= 1'b0;
         busy_q      <= 1'b0;
`ifdef UART_PKT_CHECKSUM_EN
         xor_q       <= 16'h0000;
`endif
      end else begin
         state_q     <= state_d;
         settle_q    <= settle_d;
         len_q       <= len_d;
         rem_q       <= rem_d;
         msg_start_q <= msg_start_d;
         rd_req_q    <= rd_req_d;
         tx_data_q   <= tx_data_d;
         tx_valid_q  <= tx_valid_d;
         tx_last_q   <= tx_last_d;
         busy_q      <= busy_d;
`ifdef UART_PKT_CHECKSUM_EN
         xor_q       <= xor_d;
`endif
      end
   end

   assign bus.MSG_START = msg_start_q;
   assign bus.RD_REQ    = rd_req_q;
   assign bus.TX_DATA   = tx_data_q;
   assign bus.TX_VALID  = tx_valid_q;
   assign bus.TX_LAST   = tx_last_q;
   assign bus.BUSY      = busy_q;

endmodule

// File: tb/tb_uart_msg_packetizer.sv
// Directed bench for uart_msg_packetizer: acts as the UART input stage and the
// downstream sink, then compares received packets with hand-computed words.
module tb_uart_msg_packetizer;
   logic CLK = 1'b0;
   logic RST = 1'b0;

   uart_msg_packetizer_if pkt();

   uart_msg_packetizer #(.SRC_ID(4'h1), .SETTLE_CYC(3)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (pkt)
   );

   always #5 CLK = ~CLK;

`ifdef UART_PKT_CHECKSUM_EN
   localparam logic [15:0] CK = 16'h0400;
   localparam int          NT = 1;
`else
   localparam logic [15:0] CK = 16'h0000;
   localparam int          NT = 0;
`endif
   localparam logic PL_LAST = (NT == 0);

   int checks = 0;
   int errors = 0;

   logic [15:0] fifo_mem [0:255];
   logic [15:0] rx_data  [0:259];
   logic        rx_last  [0:259];
   int rx_n, rd_cnt, ms_cnt, rd_idx, stall_cnt;
   bit stall_err, rd_early, rd_overlap;

   // Plays input stage and sink for one packet; ready follows pat per cycle.
   task automatic run_packet(input int len, input bit par, input logic [3:0] pat);
      int cyc;
      bit done, prev_stall;
      logic [15:0] prev_d;
      rx_n = 0; rd_cnt = 0; ms_cnt = 0; rd_idx = 0; stall_cnt = 0;
      stall_err = 0; rd_early = 0; rd_overlap = 0;
      pkt.MSG_LEN = len[7:0];
      pkt.PARITY_IN = par;
      pkt.GOT_FULL_MESSAGE = 1'b1;
      done = 0; prev_stall = 0; prev_d = '0; cyc = 0;
      while (!done && cyc < 2000) begin
         @(posedge CLK); #1;
         pkt.TX_READY = pat[cyc[1:0]];
         @(negedge CLK);
         if (pkt.MSG_START) begin ms_cnt++; pkt.GOT_FULL_MESSAGE = 1'b0; end
         if (pkt.RD_REQ) begin
            rd_cnt++;
            if (rx_n == 0) rd_early = 1;
            if (pkt.TX_VALID) rd_overlap = 1;
            if (rd_idx < 256) pkt.FIFO_Q = fifo_mem[rd_idx];
            rd_idx++;
         end
         if (prev_stall && (!pkt.TX_VALID || pkt.TX_DATA !== prev_d)) stall_err = 1;
         if (pkt.TX_VALID && pkt.TX_READY && rx_n < 260) begin
            rx_data[rx_n] = pkt.TX_DATA;
            rx_last[rx_n] = pkt.TX_LAST;
            rx_n++;
            if (pkt.TX_LAST) done = 1;
         end
         prev_stall = pkt.TX_VALID && !pkt.TX_READY;
         if (prev_stall) stall_cnt++;
         prev_d = pkt.TX_DATA;
         cyc++;
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL packet_timeout: no TX_LAST within %0d cycles (len %0d)", cyc, len);
      end
   endtask

   task automatic test_reset();
      pkt.GOT_FULL_MESSAGE = 1'b0; pkt.MSG_LEN = '0; pkt.PARITY_IN = 1'b0;
      pkt.FIFO_Q = '0; pkt.TX_READY = 1'b0;
      RST = 1'b0;
      repeat (2) @(negedge CLK);
      checks++;
      if ({pkt.MSG_START, pkt.RD_REQ, pkt.TX_VALID, pkt.TX_LAST, pkt.BUSY, pkt.TX_DATA} !== 21'h0) begin
         errors++;
         $display("FAIL reset_outputs: got ms=%b rd=%b v=%b l=%b busy=%b d=%h, want all 0",
                  pkt.MSG_START, pkt.RD_REQ, pkt.TX_VALID, pkt.TX_LAST, pkt.BUSY, pkt.TX_DATA);
      end
      RST = 1'b1;
      @(negedge CLK);
      checks++;
      if (pkt.BUSY !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", pkt.BUSY); end
   endtask

   task automatic test_basic();
      fifo_mem[0] = 16'h1122; fifo_mem[1] = 16'h3344; fifo_mem[2] = 16'h5566;
      run_packet(3, 1'b0, 4'b1111);
      checks++;
      if (ms_cnt !== 1) begin errors++; $display("FAIL basic_msg_start: got %0d want 1", ms_cnt); end
      checks++;
      if (rx_n !== 4 + NT) begin errors++; $display("FAIL basic_words: got %0d want %0d", rx_n, 4 + NT); end
      checks++;
      if (rx_data[0] !== (16'h1003 | CK)) begin errors++; $display("FAIL basic_header: got %h want %h", rx_data[0], 16'h1003 | CK); end
      checks++;
      if ({rx_data[1], rx_data[2], rx_data[3]} !== 48'h1122_3344_5566) begin
         errors++; $display("FAIL basic_payload: got %h %h %h want 1122 3344 5566", rx_data[1], rx_data[2], rx_data[3]);
      end
      checks++;
      if ({rx_last[0], rx_last[1], rx_last[2], rx_last[3]} !== {3'b000, PL_LAST}) begin
         errors++; $display("FAIL basic_last: got %b%b%b%b want 000%b", rx_last[0], rx_last[1], rx_last[2], rx_last[3], PL_LAST);
      end
      checks++;
      if (rd_cnt !== 3) begin errors++; $display("FAIL basic_rd_count: got %0d want 3", rd_cnt); end
      checks++;
      if (rd_early || rd_overlap) begin errors++; $display("FAIL basic_rd_order: got early=%b overlap=%b want 0 0", rd_early, rd_overlap); end
`ifdef UART_PKT_CHECKSUM_EN
      checks++;
      if (rx_data[4] !== 16'h7700 || rx_last[4] !== 1'b1) begin
         errors++; $display("FAIL basic_trailer: got %h last=%b want 7700 last=1", rx_data[4], rx_last[4]);
      end
`endif
   endtask

   task automatic test_stuffed();
      fifo_mem[0] = 16'hBEEF; fifo_mem[1] = 16'h0102;
      run_packet(2, 1'b1, 4'b1111);
      checks++;
      if (rx_data[0] !== (16'h1802 | CK)) begin errors++; $display("FAIL stuffed_header: got %h want %h", rx_data[0], 16'h1802 | CK); end
      checks++;
      if (rx_data[1] !== 16'hBEEF || rx_data[2] !== 16'h0102) begin
         errors++; $display("FAIL stuffed_payload: got %h %h want beef 0102", rx_data[1], rx_data[2]);
      end
      checks++;
      if (rx_last[1] !== 1'b0 || rx_last[2] !== PL_LAST) begin
         errors++; $display("FAIL stuffed_last: got %b%b want 0%b", rx_last[1], rx_last[2], PL_LAST);
      end
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < 4; i++) fifo_mem[i] = 16'hA001 + 16'(i);
      run_packet(4, 1'b0, 4'b1001);
      checks++;
      if (rx_data[0] !== (16'h1004 | CK)) begin errors++; $display("FAIL bp_header: got %h want %h", rx_data[0], 16'h1004 | CK); end
      checks++;
      if ({rx_data[1], rx_data[2], rx_data[3], rx_data[4]} !== 64'hA001_A002_A003_A004) begin
         errors++; $display("FAIL bp_payload: got %h %h %h %h want a001..a004", rx_data[1], rx_data[2], rx_data[3], rx_data[4]);
      end
      checks++;
      if (stall_err || stall_cnt == 0) begin errors++; $display("FAIL bp_stable: got unstable=%b stalls=%0d want 0 and >0", stall_err, stall_cnt); end
      checks++;
      if (rd_cnt !== 4 || rd_overlap) begin errors++; $display("FAIL bp_rd_count: got %0d overlap=%b want 4 0", rd_cnt, rd_overlap); end
      checks++;
      if (rx_last[4] !== PL_LAST) begin errors++; $display("FAIL bp_last: got %b want %b", rx_last[4], PL_LAST); end
   endtask

   task automatic test_zero_len();
      run_packet(0, 1'b0, 4'b1111);
      checks++;
      if (rx_n !== 1 + NT || rx_data[0] !== (16'h1000 | CK)) begin
         errors++; $display("FAIL zero_header: got n=%0d %h want n=%0d %h", rx_n, rx_data[0], 1 + NT, 16'h1000 | CK);
      end
      checks++;
      if (rx_last[0] !== PL_LAST) begin errors++; $display("FAIL zero_last: got %b want %b", rx_last[0], PL_LAST); end
`ifdef UART_PKT_CHECKSUM_EN
      checks++;
      if (rx_data[1] !== 16'h0000 || rx_last[1] !== 1'b1) begin
         errors++; $display("FAIL zero_trailer: got %h last=%b want 0000 last=1", rx_data[1], rx_last[1]);
      end
`endif
      checks++;
      if (rd_cnt !== 0) begin errors++; $display("FAIL zero_rd: got %0d want 0", rd_cnt); end
      @(negedge CLK);
      checks++;
      if (pkt.BUSY !== 1'b1 || pkt.TX_VALID !== 1'b0) begin
         errors++; $display("FAIL zero_done: got busy=%b valid=%b want 1 0", pkt.BUSY, pkt.TX_VALID);
      end
      @(negedge CLK);
      checks++;
      if (pkt.BUSY !== 1'b0) begin errors++; $display("FAIL zero_idle: got busy=%b want 0", pkt.BUSY); end
   endtask

   task automatic test_max_len();
      int bad;
      for (int i = 0; i < 255; i++) fifo_mem[i] = {i[7:0], ~i[7:0]};
      run_packet(255, 1'b0, 4'b1111);
      bad = 0;
      for (int i = 0; i < 255; i++) begin
         if (rx_data[i + 1] !== {i[7:0], ~i[7:0]} || rx_last[i + 1] !== ((i == 254) ? PL_LAST : 1'b0)) bad++;
      end
      checks++;
      if (rx_data[0] !== (16'h10FF | CK)) begin errors++; $display("FAIL max_header: got %h want %h", rx_data[0], 16'h10FF | CK); end
      checks++;
      if (bad !== 0 || rx_n !== 256 + NT) begin errors++; $display("FAIL max_payload: got bad=%0d n=%0d want 0 %0d", bad, rx_n, 256 + NT); end
      checks++;
      if (rd_cnt !== 255) begin errors++; $display("FAIL max_rd_count: got %0d want 255", rd_cnt); end
   endtask

   task automatic test_reset_mid();
      bit found;
      for (int i = 0; i < 5; i++) fifo_mem[i] = 16'hC001 + 16'(i);
      pkt.MSG_LEN = 8'd5; pkt.PARITY_IN = 1'b0; pkt.TX_READY = 1'b1;
      pkt.GOT_FULL_MESSAGE = 1'b1;
      rd_idx = 0; found = 0;
      for (int c = 0; c < 200 && !found; c++) begin
         @(negedge CLK);
         if (pkt.MSG_START) pkt.GOT_FULL_MESSAGE = 1'b0;
         if (pkt.RD_REQ) begin pkt.FIFO_Q = fifo_mem[rd_idx]; rd_idx++; end
         if (pkt.TX_VALID && pkt.TX_DATA === 16'hC002) found = 1;
      end
      checks++;
      if (!found) begin errors++; $display("FAIL midrst_reach: got no second word want c002"); end
      RST = 1'b0;
      #1;
      checks++;
      if ({pkt.MSG_START, pkt.RD_REQ, pkt.TX_VALID, pkt.TX_LAST, pkt.BUSY, pkt.TX_DATA} !== 21'h0) begin
         errors++;
         $display("FAIL midrst_outputs: got ms=%b rd=%b v=%b l=%b busy=%b d=%h, want all 0",
                  pkt.MSG_START, pkt.RD_REQ, pkt.TX_VALID, pkt.TX_LAST, pkt.BUSY, pkt.TX_DATA);
      end
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      fifo_mem[0] = 16'h7777;
      run_packet(1, 1'b0, 4'b1111);
      checks++;
      if (ms_cnt !== 1 || rx_data[0] !== (16'h1001 | CK)) begin
         errors++; $display("FAIL midrst_restart: got ms=%0d hdr=%h want 1 %h", ms_cnt, rx_data[0], 16'h1001 | CK);
      end
      checks++;
      if (rx_data[1] !== 16'h7777 || rd_cnt !== 1) begin
         errors++; $display("FAIL midrst_payload: got %h rd=%0d want 7777 1", rx_data[1], rd_cnt);
      end
   endtask

`ifdef UART_PKT_CHECKSUM_EN
   task automatic test_checksum();
      fifo_mem[0] = 16'hA5A5; fifo_mem[1] = 16'h0F0F;
      run_packet(2, 1'b0, 4'b1111);
      checks++;
      if (rx_data[0] !== 16'h1402) begin errors++; $display("FAIL ck_header: got %h want 1402", rx_data[0]); end
      checks++;
      if (rx_last[1] !== 1'b0 || rx_last[2] !== 1'b0) begin errors++; $display("FAIL ck_payload_last: got %b%b want 00", rx_last[1], rx_last[2]); end
      checks++;
      if (rx_data[3] !== 16'hAAAA || rx_last[3] !== 1'b1) begin
         errors++; $display("FAIL ck_trailer: got %h last=%b want aaaa last=1", rx_data[3], rx_last[3]);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_stuffed();
      test_backpressure();
      test_zero_len();
`ifdef UART_PKT_CHECKSUM_EN
      test_checksum();
`endif
      test_max_len();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
